// File: rtl/fc_pkg.sv
// Shared encodings for the fully-connected ALU sequencer: load_enable codes,
// FSM state enum and the fixed-point ONE constant.
package fc_pkg;

    localparam logic [1:0] LOAD_VALUES       = 2'd0;
    localparam logic [1:0] LOAD_BIAS_WEIGHTS = 2'd1;
    localparam logic [1:0] LOAD_UD           = 2'd2;

    localparam int          FC_PRECISION = 11;
    localparam logic [15:0] FC_ONE       = 16'(1 << FC_PRECISION);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GET_WB,
        LOAD_WB,
        GET_V,
        LOAD_V,
        ACCUM,
        RESULT
    } fc_state_e;

endpackage

// File: rtl/fc_frame_buffer.sv
// Indexed word buffer that assembles one ALU frame (slot 0 = bias, 1..INPUT_SZ = lanes)
// from the input stream; frame_nxt already includes the word written this cycle.
module fc_frame_buffer #(
    parameter int SIZE     = 16,
    parameter int INPUT_SZ = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_wb,
    input  logic                         init_v,
    input  logic                         bias_zero,
    input  logic                         wr_en,
    input  logic [SIZE-1:0]              wr_data,
    output logic                         frame_done,
    output logic [(INPUT_SZ+1)*SIZE-1:0] frame_nxt
);

    localparam int             IW   = $clog2(INPUT_SZ + 1);
    localparam logic [IW-1:0]  LAST = IW'(INPUT_SZ);

    logic [0:INPUT_SZ][SIZE-1:0] fbuf_q, fbuf_d;
    logic [IW-1:0]               idx_q, idx_d;

    // A values frame starts at slot 1 with slot 0 zeroed; the bias word of
    // later chunks is still consumed but written as zero.
    always_comb begin
        fbuf_d = fbuf_q;
        idx_d  = idx_q;
        if (init_wb) begin
            idx_d = '0;
        end
        if (init_v) begin
            idx_d     = IW'(1);
            fbuf_d[0] = '0;
        end
        if (wr_en) begin
            fbuf_d[idx_q] = (idx_q == '0 && bias_zero) ? '0 : wr_data;
            idx_d         = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbuf_q <= '0;
            idx_q  <= '0;
        end else begin
            fbuf_q <= fbuf_d;
            idx_q  <= idx_d;
        end
    end

    assign frame_done = wr_en && (idx_q == LAST);
    assign frame_nxt  = fbuf_d;

endmodule

// File: rtl/fc_alu_sequencer.sv
// Drives the FC ALU load/accumulate handshake over NUM_CHUNKS chunks per neuron.
// Optional build macro FC_SEQ_RELU_EN: clamp negative results to zero at capture.
module fc_alu_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int PRECISION  = 11,
    parameter int INPUT_SZ   = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    input  logic [SIZE-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [(INPUT_SZ+1)*SIZE-1:0] alu_values,
    output logic [1:0]                   alu_load_enable,
    output logic                         alu_enable,
    output logic                         alu_clear,
    input  logic [SIZE-1:0]              alu_value,
    output logic [SIZE-1:0]              out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int            CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    generate
        if (PRECISION >= SIZE || NUM_CHUNKS < 1) begin : g_bad_cfg
            $error("fc_alu_sequencer: unsupported PRECISION or NUM_CHUNKS");
        end
    endgenerate

    fc_state_e                     state_q, state_d;
    logic [CW-1:0]                 chunk_q, chunk_d;
    logic                          init_wb, init_v, frame_done, wr_en;
    logic [(INPUT_SZ+1)*SIZE-1:0]  frame_nxt;
    logic [SIZE-1:0]               result_d;

    assign wr_en = in_valid && in_ready;

    fc_frame_buffer #(
        .SIZE     (SIZE),
        .INPUT_SZ (INPUT_SZ)
    ) u_fbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_wb    (init_wb),
        .init_v     (init_v),
        .bias_zero  (chunk_q != '0),
        .wr_en      (wr_en),
        .wr_data    (in_data),
        .frame_done (frame_done),
        .frame_nxt  (frame_nxt)
    );

`ifdef FC_SEQ_RELU_EN
    assign result_d = alu_value[SIZE-1] ? '0 : alu_value;
`else
    assign result_d = alu_value;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        init_wb = 1'b0;
        init_v  = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR: begin
                chunk_d = '0;
                init_wb = 1'b1;
                state_d = GET_WB;
            end
            GET_WB:  if (frame_done) state_d = LOAD_WB;
            LOAD_WB: begin
                init_v  = 1'b1;
                state_d = GET_V;
            end
            GET_V:   if (frame_done) state_d = LOAD_V;
            LOAD_V:  state_d = ACCUM;
            ACCUM: begin
                if (chunk_q == LAST_CHUNK) begin
                    state_d = RESULT;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                    init_wb = 1'b1;
                    state_d = GET_WB;
                end
            end
            RESULT:  if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            in_ready        <= 1'b0;
            alu_values      <= '0;
            alu_load_enable <= LOAD_UD;
            alu_enable      <= 1'b0;
            alu_clear       <= 1'b0;
            out_data        <= '0;
            out_valid       <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            in_ready   <= (state_d == GET_WB) || (state_d == GET_V);
            alu_clear  <= (state_d == CLEAR);
            alu_enable <= (state_d == ACCUM);
            case (state_d)
                LOAD_WB: alu_load_enable <= LOAD_BIAS_WEIGHTS;
                LOAD_V:  alu_load_enable <= LOAD_VALUES;
                default: alu_load_enable <= LOAD_UD;
            endcase
            if (state_d == LOAD_WB || state_d == LOAD_V) begin
                alu_values <= frame_nxt;
            end
            // First RESULT cycle lets the accumulator settle; capture at its end.
            if (state_q == RESULT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= result_d;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
